axis_rr_arbiter: RTL and testbench
==================================

Name: axis_rr_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one downstream AXI-Stream sink (e.g. our buffering AXIS slave/FIFO) among NUM_SRC upstream AXI-Stream masters.
- Grant is held for a whole packet, from first beat through the TLAST beat, so packets are never interleaved.
- Sits between the source streams and the shared sink.
- Also reports the current owner and counts forwarded packets and beats.

Parameters:
- NUM_SRC, 4, number of upstream streams; legal range 2..16.
- DATA_WIDTH, 32, TDATA width in bits; multiple of 8.
- IDX_W, clogb2(NUM_SRC-1), grant index width; derived localparam, not overridable.

Ports:
- ACLK  in  1  clock, all logic rising-edge.
- ARESET  in  1  reset, synchronous, active-high.
- S_AXIS_TVALID  in  NUM_SRC  per-source valid.
- S_AXIS_TREADY  out  NUM_SRC  per-source ready.
- S_AXIS_TDATA  in  NUM_SRC*DATA_WIDTH  source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- S_AXIS_TSTRB  in  NUM_SRC*DATA_WIDTH/8  packed the same way as TDATA.
- S_AXIS_TLAST  in  NUM_SRC  per-source last.
- M_AXIS_TVALID  out  1  merged valid.
- M_AXIS_TREADY  in  1  sink ready.
- M_AXIS_TDATA  out  DATA_WIDTH  merged data.
- M_AXIS_TSTRB  out  DATA_WIDTH/8  merged strobe.
- M_AXIS_TLAST  out  1  merged last.
- GRANT_VLD  out  1  a source currently owns the output.
- GRANT_IDX  out  IDX_W  owning source index.
- PKT_CNT  out  32  packets forwarded (TLAST beats accepted); wraps at 2^32.
- BEAT_CNT  out  16  beats of the current packet accepted so far; saturates at 16'hFFFF.

Behaviour:
- State machine: IDLE, BUSY.
- Reset (ARESET=1 at a clock edge) forces:
  - state=IDLE, GRANT_VLD=0, GRANT_IDX=0;
  - round-robin pointer last=NUM_SRC-1, so source 0 has first priority;
  - PKT_CNT=0, BEAT_CNT=0.
- Reset during a packet drops the grant immediately. The partial packet is not completed. Upstream sources must be reset alongside.
- Outputs while in IDLE:
  - M_AXIS_TVALID=0 and every S_AXIS_TREADY bit = 0.
  - M_AXIS_TDATA, TSTRB and TLAST are don't-care; implementation drives 0.
- IDLE -> BUSY:
  - Taken when any S_AXIS_TVALID bit is 1.
  - Winner = first set bit scanning last+1, last+2, ... modulo NUM_SRC.
  - GRANT_IDX and GRANT_VLD are registered on that edge.
  - Arbitration latency is 1 cycle: winner's first beat can transfer in the cycle after its TVALID is first seen in IDLE.
- BUSY, with g = GRANT_IDX:
  - M_AXIS_TVALID/TDATA/TSTRB/TLAST = source g's signals, combinational.
  - S_AXIS_TREADY[g] = M_AXIS_TREADY; all other ready bits = 0.
  - No registered stage in the data path: zero added latency while granted.
- Beat accept: M_AXIS_TVALID & M_AXIS_TREADY → BEAT_CNT+1 (saturating).
- Accepted beat with TLAST=1:
  - PKT_CNT+1, BEAT_CNT cleared to 0, last=g, GRANT_VLD=0;
  - state→IDLE on that edge.
  - The next grant takes one IDLE cycle: one bubble between packets by design.
- Source g dropping TVALID mid-packet: grant is held, no timeout; the arbiter waits.
- Other sources raising TVALID during BUSY: no effect until IDLE.
- Single-beat packet (TLAST on first beat): counted as a full packet, BEAT_CNT returns to 0.
- Only one requester: it is re-granted after each packet (with the 1-cycle bubble).
- M_AXIS_TREADY stuck low: grant held indefinitely, BEAT_CNT does not change.
- Protocol: TVALID, TDATA and TLAST of the granted source must be held while stalled (AXIS rule). The arbiter never deasserts M_AXIS_TVALID on its own while BUSY.

Optional Feature:
- Macro: AXIS_ARB_TDEST_EN.
- When defined:
  - Adds output M_AXIS_TDEST [IDX_W-1:0] = GRANT_IDX while BUSY, 0 in IDLE.
  - Downstream can demultiplex by source.
  - Valid on every beat, stable within a packet.
- When undefined: port absent; behaviour otherwise identical.

Test Plan:
- Reset, all TVALID=0, M_AXIS_TREADY=1 → M_AXIS_TVALID=0, S_AXIS_TREADY=0, GRANT_VLD=0, PKT_CNT=0.
- Sources 0..3 each present one 4-beat packet simultaneously, M_AXIS_TREADY=1 → grant order 0,1,2,3. Each packet is 4 contiguous beats with one idle cycle between packets. PKT_CNT=4 after 20 cycles.
- Source 2 only, 3 packets of 1 beat (data 0xA5A5_0001..3) → three grants to index 2, output data in order, PKT_CNT=3, BEAT_CNT=0.
- Source 1 streaming 8-beat packet, source 0 raises TVALID at beat 3 → no switch until source 1's TLAST is accepted, then grant 0. S_AXIS_TREADY[0]=0 throughout source 1's packet.
- M_AXIS_TREADY toggles 1010..., source 3 withholds TVALID for 2 cycles mid-packet → no lost or duplicated beats, BEAT_CNT counts only handshakes, grant stays 3.
- ARESET pulsed at beat 2 of a 6-beat packet from source 1 → next cycle GRANT_VLD=0, all counters 0. With sources 0 and 1 requesting, the next grant goes to source 0. With AXIS_ARB_TDEST_EN, M_AXIS_TDEST equals the grant index on every beat.

Source files
------------

// File: rtl/axis_rr_arbiter.sv
//-----------------------------------------------------------------------------
// axis_rr_arbiter
//
// Packet-granular round-robin arbiter. It shares one downstream AXI-Stream
// sink among NUM_SRC upstream AXI-Stream masters. A grant is held from the
// first beat of a packet through its TLAST beat, so packets never interleave.
// The data path is purely combinational while a source is granted. Each
// packet boundary costs one IDLE cycle, which is where re-arbitration happens.
//
// Parameters:
//   NUM_SRC     number of upstream streams (2..16)
//   DATA_WIDTH  TDATA width in bits (multiple of 8)
//   IDX_W       grant index width (derived, not overridable)
//
// Ports:
//   ACLK, ARESET      rising-edge clock; synchronous active-high reset
//   S_AXIS_*          NUM_SRC packed slave streams. Source i occupies
//                     slice [i*W +: W] of TDATA and TSTRB.
//   M_AXIS_*          merged master stream toward the shared sink
//   M_AXIS_TDEST      (only with AXIS_ARB_TDEST_EN) index of the source
//                     that owns the current beat
//   GRANT_VLD         a source currently owns the output
//   GRANT_IDX         index of the owning source
//   PKT_CNT           packets forwarded (TLAST beats accepted); wraps
//   BEAT_CNT          beats of the current packet accepted; saturates
//
// Optional feature macro: AXIS_ARB_TDEST_EN
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module axis_rr_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 32,
  // Bits needed to hold NUM_SRC-1, i.e. clogb2(NUM_SRC-1)
  localparam int IDX_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int STRB_W    = DATA_WIDTH / 8
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [NUM_SRC-1:0]            S_AXIS_TVALID,
  output logic [NUM_SRC-1:0]            S_AXIS_TREADY,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic [NUM_SRC*STRB_W-1:0]     S_AXIS_TSTRB,
  input  logic [NUM_SRC-1:0]            S_AXIS_TLAST,
  output logic                          M_AXIS_TVALID,
  input  logic                          M_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0]         M_AXIS_TDATA,
  output logic [STRB_W-1:0]             M_AXIS_TSTRB,
  output logic                          M_AXIS_TLAST,
`ifdef AXIS_ARB_TDEST_EN
  output logic [IDX_W-1:0]              M_AXIS_TDEST,
`endif
  output logic                          GRANT_VLD,
  output logic [IDX_W-1:0]              GRANT_IDX,
  output logic [31:0]                   PKT_CNT,
  output logic [15:0]                   BEAT_CNT
);

  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  state_t                  state, next_state;
  logic [IDX_W-1:0]        grant_idx;
  logic [IDX_W-1:0]        last_ptr;
  logic [IDX_W-1:0]        winner;
  logic                    any_req;
  logic                    sel_valid;
  logic                    sel_last;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [STRB_W-1:0]       sel_strb;
  logic                    beat_accept;
  logic                    last_accept;
  logic [31:0]             pkt_cnt;
  logic [15:0]             beat_cnt;

  assign any_req = |S_AXIS_TVALID;

  // Round-robin winner: the first requester in scan order last+1, last+2, ...
  // (mod NUM_SRC). The scan walks from the farthest distance down to the
  // nearest, so the nearest requester is assigned last and wins.
  always_comb begin
    winner = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (S_AXIS_TVALID[i] &&
            ((int'(last_ptr) + k == i) || (int'(last_ptr) + k == i + NUM_SRC)))
          winner = IDX_W'(i);
      end
    end
  end

  // Select the granted source's signals. A compare-per-source mux keeps all
  // slices constant and leaves unused index codes harmless.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_strb  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_valid = S_AXIS_TVALID[i];
        sel_last  = S_AXIS_TLAST[i];
        sel_data  = S_AXIS_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
        sel_strb  = S_AXIS_TSTRB[i*STRB_W +: STRB_W];
      end
    end
  end

  assign beat_accept = (state == BUSY) && sel_valid && M_AXIS_TREADY;
  assign last_accept = beat_accept && sel_last;

  // State register
  always_ff @(posedge ACLK) begin
    if (ARESET)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Next-state and stream outputs. IDLE blocks every source. BUSY passes the
  // granted source straight through and routes sink ready back only to it.
  always_comb begin
    next_state    = state;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = '0;
    M_AXIS_TSTRB  = '0;
    M_AXIS_TLAST  = 1'b0;
    S_AXIS_TREADY = '0;
    case (state)
      IDLE: begin
        if (any_req)
          next_state = BUSY;
      end
      BUSY: begin
        M_AXIS_TVALID = sel_valid;
        M_AXIS_TDATA  = sel_data;
        M_AXIS_TSTRB  = sel_strb;
        M_AXIS_TLAST  = sel_last;
        for (int i = 0; i < NUM_SRC; i++)
          S_AXIS_TREADY[i] = M_AXIS_TREADY && (grant_idx == IDX_W'(i));
        if (last_accept)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Grant index, round-robin pointer and counters. The grant is captured on
  // the IDLE->BUSY edge. The pointer moves only when a packet completes, so
  // the source that just finished drops to the lowest priority.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      grant_idx <= '0;
      last_ptr  <= IDX_W'(NUM_SRC - 1);
      pkt_cnt   <= '0;
      beat_cnt  <= '0;
    end else begin
      if (state == IDLE && any_req)
        grant_idx <= winner;
      if (last_accept) begin
        last_ptr <= grant_idx;
        pkt_cnt  <= pkt_cnt + 32'd1;
        beat_cnt <= '0;
      end else if (beat_accept && beat_cnt != 16'hFFFF) begin
        beat_cnt <= beat_cnt + 16'd1;
      end
    end
  end

  // The grant is valid exactly while the registered state is BUSY.
  assign GRANT_VLD = (state == BUSY);
  assign GRANT_IDX = grant_idx;
  assign PKT_CNT   = pkt_cnt;
  assign BEAT_CNT  = beat_cnt;

`ifdef AXIS_ARB_TDEST_EN
  assign M_AXIS_TDEST = (state == BUSY) ? grant_idx : '0;
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
//-----------------------------------------------------------------------------
// tb_axis_rr_arbiter
//
// Directed scoreboard bench for axis_rr_arbiter (NUM_SRC=4, DATA_WIDTH=32).
// applyStimulus queues beats on a source and pushes the expected merged beats
// in hand-computed grant order. The driver process presents the queued beats.
// The monitor pops one expected beat for each output handshake and compares
// it. The main sequence also checks grant and counter state at hand-computed
// cycles.
//
// Optional feature macro: AXIS_ARB_TDEST_EN
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_axis_rr_arbiter;

  localparam int NUM_SRC = 4;
  localparam int DW      = 32;
  localparam int SW      = DW / 8;

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
    int            gap;
  } beat_t;

  typedef struct {
    int            src;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
  } exp_t;

  logic                    clk;
  logic                    ARESET;
  logic [NUM_SRC-1:0]      S_AXIS_TVALID;
  logic [NUM_SRC-1:0]      S_AXIS_TREADY;
  logic [NUM_SRC*DW-1:0]   S_AXIS_TDATA;
  logic [NUM_SRC*SW-1:0]   S_AXIS_TSTRB;
  logic [NUM_SRC-1:0]      S_AXIS_TLAST;
  logic                    M_AXIS_TVALID;
  logic                    M_AXIS_TREADY;
  logic [DW-1:0]           M_AXIS_TDATA;
  logic [SW-1:0]           M_AXIS_TSTRB;
  logic                    M_AXIS_TLAST;
`ifdef AXIS_ARB_TDEST_EN
  logic [1:0]              M_AXIS_TDEST;
`endif
  logic                    GRANT_VLD;
  logic [1:0]              GRANT_IDX;
  logic [31:0]             PKT_CNT;
  logic [15:0]             BEAT_CNT;

  beat_t src_q [NUM_SRC][$];
  exp_t  exp_q [$];
  int    checks;
  int    failures;
  logic  ready_toggle;
  logic  flush_req;

  axis_rr_arbiter #(.NUM_SRC(NUM_SRC), .DATA_WIDTH(DW)) dut (
    .ACLK          (clk),
    .ARESET        (ARESET),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TSTRB  (S_AXIS_TSTRB),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TSTRB  (M_AXIS_TSTRB),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
`ifdef AXIS_ARB_TDEST_EN
    .M_AXIS_TDEST  (M_AXIS_TDEST),
`endif
    .GRANT_VLD     (GRANT_VLD),
    .GRANT_IDX     (GRANT_IDX),
    .PKT_CNT       (PKT_CNT),
    .BEAT_CNT      (BEAT_CNT)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Queues a packet on one source and records its expected merged beats.
  // gap_len idle cycles are inserted before beat gap_beat is presented.
  task automatic applyStimulus(input int src, input int nbeats,
                               input logic [31:0] base, input int gap_beat,
                               input int gap_len);
    beat_t b;
    exp_t  e;
    for (int i = 0; i < nbeats; i++) begin
      b.data = base + 32'(i);
      b.last = (i == nbeats - 1);
      b.strb = b.last ? 4'h3 : 4'hF;
      b.gap  = (i == gap_beat) ? gap_len : 0;
      src_q[src].push_back(b);
      e.src  = src;
      e.data = b.data;
      e.strb = b.strb;
      e.last = b.last;
      exp_q.push_back(e);
    end
  endtask

  // Holds reset across one rising edge. Upstream sources are flushed at the
  // same edge.
  task automatic applyReset();
    ARESET    = 1'b1;
    flush_req = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #2;
    ARESET = 1'b0;
    @(negedge clk);
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // Source driver: advances each source's queue on accepted beats and applies
  // the requested valid gaps. It also drives sink ready, either steady high
  // or toggling every cycle.
  initial begin
    logic [NUM_SRC-1:0]    fire;
    logic [NUM_SRC-1:0]    v;
    logic [NUM_SRC-1:0]    l;
    logic [NUM_SRC*DW-1:0] d;
    logic [NUM_SRC*SW-1:0] s;
    int                    hold_cnt [NUM_SRC];
    bit                    loaded   [NUM_SRC];
    for (int i = 0; i < NUM_SRC; i++) begin
      hold_cnt[i] = 0;
      loaded[i]   = 1'b0;
    end
    S_AXIS_TVALID = '0;
    S_AXIS_TDATA  = '0;
    S_AXIS_TSTRB  = '0;
    S_AXIS_TLAST  = '0;
    M_AXIS_TREADY = 1'b1;
    forever begin
      @(negedge clk);
      fire = S_AXIS_TVALID & S_AXIS_TREADY & {NUM_SRC{~ARESET}};
      @(posedge clk);
      #1;
      if (flush_req) begin
        for (int i = 0; i < NUM_SRC; i++) begin
          src_q[i].delete();
          loaded[i]   = 1'b0;
          hold_cnt[i] = 0;
        end
        flush_req = 1'b0;
      end else begin
        for (int i = 0; i < NUM_SRC; i++)
          if (fire[i] && src_q[i].size() != 0) begin
            void'(src_q[i].pop_front());
            loaded[i] = 1'b0;
          end
      end
      v = '0; l = '0; d = '0; s = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_q[i].size() != 0) begin
          if (!loaded[i]) begin
            hold_cnt[i] = src_q[i][0].gap;
            loaded[i]   = 1'b1;
          end
          if (hold_cnt[i] > 0) begin
            hold_cnt[i]--;
          end else begin
            v[i]             = 1'b1;
            l[i]             = src_q[i][0].last;
            d[i*DW +: DW]    = src_q[i][0].data;
            s[i*SW +: SW]    = src_q[i][0].strb;
          end
        end
      end
      S_AXIS_TVALID = v;
      S_AXIS_TLAST  = l;
      S_AXIS_TDATA  = d;
      S_AXIS_TSTRB  = s;
      M_AXIS_TREADY = ready_toggle ? ~M_AXIS_TREADY : 1'b1;
    end
  end

  // Monitor: every output handshake consumes one expected beat.
  initial begin
    exp_t e;
    logic ok;
    forever begin
      @(negedge clk);
      if (!ARESET && M_AXIS_TVALID && M_AXIS_TREADY) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL beat_unexpected: got src=%0d data=0x%0h last=%b, expected no beat",
                   GRANT_IDX, M_AXIS_TDATA, M_AXIS_TLAST);
        end else begin
          e  = exp_q.pop_front();
          ok = (M_AXIS_TDATA === e.data) && (M_AXIS_TSTRB === e.strb) &&
               (M_AXIS_TLAST === e.last) && (GRANT_IDX === 2'(e.src)) &&
               (GRANT_VLD === 1'b1);
`ifdef AXIS_ARB_TDEST_EN
          ok = ok && (M_AXIS_TDEST === 2'(e.src));
`endif
          if (!ok) begin
            failures++;
            $display("[TB] FAIL beat: got src=%0d data=0x%0h strb=0x%0h last=%b, expected src=%0d data=0x%0h strb=0x%0h last=%b",
                     GRANT_IDX, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST,
                     e.src, e.data, e.strb, e.last);
          end
        end
      end
    end
  end

  initial begin
    checks       = 0;
    failures     = 0;
    ARESET       = 1'b1;
    ready_toggle = 1'b0;
    flush_req    = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    ARESET = 1'b0;
    @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_m_tvalid", 32'(M_AXIS_TVALID), 32'd0);
    checkOutput("rst_s_tready", 32'(S_AXIS_TREADY), 32'd0);
    checkOutput("rst_grant_vld", 32'(GRANT_VLD), 32'd0);
    checkOutput("rst_grant_idx", 32'(GRANT_IDX), 32'd0);
    checkOutput("rst_pkt_cnt", PKT_CNT, 32'd0);
    checkOutput("rst_beat_cnt", 32'(BEAT_CNT), 32'd0);
`ifdef AXIS_ARB_TDEST_EN
    checkOutput("rst_tdest", 32'(M_AXIS_TDEST), 32'd0);
`endif

    $display("[TB] four simultaneous 4-beat packets");
    applyReset();
    for (int s = 0; s < NUM_SRC; s++)
      applyStimulus(s, 4, 32'h1000_0000 | (32'(s) << 8), -1, 0);
    stepCycles(2);
    checkOutput("rr_p1_grant_vld", 32'(GRANT_VLD), 32'd1);
    checkOutput("rr_p1_grant_idx", 32'(GRANT_IDX), 32'd0);
    checkOutput("rr_p1_s_tready", 32'(S_AXIS_TREADY), 32'h1);
    checkOutput("rr_p1_beat_cnt", 32'(BEAT_CNT), 32'd0);
    stepCycles(1);
    checkOutput("rr_p2_beat_cnt", 32'(BEAT_CNT), 32'd1);
    stepCycles(3);
    checkOutput("rr_p5_grant_vld", 32'(GRANT_VLD), 32'd0);
    checkOutput("rr_p5_pkt_cnt", PKT_CNT, 32'd1);
    checkOutput("rr_p5_beat_cnt", 32'(BEAT_CNT), 32'd0);
    stepCycles(1);
    checkOutput("rr_p6_grant_idx", 32'(GRANT_IDX), 32'd1);
    stepCycles(13);
    checkOutput("rr_p19_pkt_cnt", PKT_CNT, 32'd3);
    checkOutput("rr_p19_grant_idx", 32'(GRANT_IDX), 32'd3);
    stepCycles(1);
    checkOutput("rr_p20_pkt_cnt", PKT_CNT, 32'd4);
    checkOutput("rr_p20_grant_vld", 32'(GRANT_VLD), 32'd0);
    waitDrain(20);

    $display("[TB] single requester, single-beat packets");
    applyReset();
    for (int k = 1; k <= 3; k++)
      applyStimulus(2, 1, 32'hA5A5_0000 + 32'(k), -1, 0);
    stepCycles(2);
    checkOutput("one_p1_grant_idx", 32'(GRANT_IDX), 32'd2);
    checkOutput("one_p1_grant_vld", 32'(GRANT_VLD), 32'd1);
    stepCycles(2);
    checkOutput("one_p3_grant_idx", 32'(GRANT_IDX), 32'd2);
    checkOutput("one_p3_pkt_cnt", PKT_CNT, 32'd1);
    stepCycles(3);
    checkOutput("one_p6_pkt_cnt", PKT_CNT, 32'd3);
    checkOutput("one_p6_beat_cnt", 32'(BEAT_CNT), 32'd0);
    checkOutput("one_p6_grant_vld", 32'(GRANT_VLD), 32'd0);
    waitDrain(20);

    $display("[TB] late requester waits for packet end");
    applyReset();
    applyStimulus(1, 8, 32'h2000_0100, -1, 0);
    applyStimulus(0, 2, 32'h2000_0000, 0, 4);
    stepCycles(2);
    checkOutput("hold_p1_grant_idx", 32'(GRANT_IDX), 32'd1);
    stepCycles(4);
    checkOutput("hold_p5_grant_idx", 32'(GRANT_IDX), 32'd1);
    checkOutput("hold_p5_s_tready", 32'(S_AXIS_TREADY), 32'h2);
    stepCycles(3);
    checkOutput("hold_p8_beat_cnt", 32'(BEAT_CNT), 32'd7);
    checkOutput("hold_p8_s_tready", 32'(S_AXIS_TREADY), 32'h2);
    stepCycles(1);
    checkOutput("hold_p9_grant_vld", 32'(GRANT_VLD), 32'd0);
    checkOutput("hold_p9_pkt_cnt", PKT_CNT, 32'd1);
    checkOutput("hold_p9_s_tready", 32'(S_AXIS_TREADY), 32'd0);
    stepCycles(1);
    checkOutput("hold_p10_grant_idx", 32'(GRANT_IDX), 32'd0);
    checkOutput("hold_p10_grant_vld", 32'(GRANT_VLD), 32'd1);
    stepCycles(2);
    checkOutput("hold_p12_pkt_cnt", PKT_CNT, 32'd2);
    waitDrain(20);

    $display("[TB] toggling sink ready and source gap");
    applyReset();
    ready_toggle = 1'b1;
    applyStimulus(3, 5, 32'h3000_0300, 2, 2);
    stepCycles(3);
    checkOutput("bp_p2_beat_cnt", 32'(BEAT_CNT), 32'd1);
    checkOutput("bp_p2_grant_idx", 32'(GRANT_IDX), 32'd3);
    stepCycles(3);
    checkOutput("bp_p5_m_tvalid", 32'(M_AXIS_TVALID), 32'd0);
    checkOutput("bp_p5_grant_vld", 32'(GRANT_VLD), 32'd1);
    checkOutput("bp_p5_beat_cnt", 32'(BEAT_CNT), 32'd2);
    stepCycles(1);
    checkOutput("bp_p6_beat_cnt", 32'(BEAT_CNT), 32'd2);
    checkOutput("bp_p6_m_tvalid", 32'(M_AXIS_TVALID), 32'd1);
    stepCycles(1);
    checkOutput("bp_p7_beat_cnt", 32'(BEAT_CNT), 32'd2);
    stepCycles(1);
    checkOutput("bp_p8_beat_cnt", 32'(BEAT_CNT), 32'd3);
    stepCycles(2);
    checkOutput("bp_p10_beat_cnt", 32'(BEAT_CNT), 32'd4);
    checkOutput("bp_p10_grant_idx", 32'(GRANT_IDX), 32'd3);
    stepCycles(2);
    checkOutput("bp_p12_pkt_cnt", PKT_CNT, 32'd1);
    checkOutput("bp_p12_beat_cnt", 32'(BEAT_CNT), 32'd0);
    checkOutput("bp_p12_grant_vld", 32'(GRANT_VLD), 32'd0);
    ready_toggle = 1'b0;
    waitDrain(20);

    $display("[TB] reset in the middle of a packet");
    applyReset();
    applyStimulus(1, 6, 32'h4000_0100, -1, 0);
    stepCycles(2);
    checkOutput("mrst_p1_grant_idx", 32'(GRANT_IDX), 32'd1);
    repeat (2) @(posedge clk);
    #2;
    checkOutput("mrst_p3_beat_cnt", 32'(BEAT_CNT), 32'd2);
    applyReset();
    checkOutput("mrst_grant_vld", 32'(GRANT_VLD), 32'd0);
    checkOutput("mrst_pkt_cnt", PKT_CNT, 32'd0);
    checkOutput("mrst_beat_cnt", 32'(BEAT_CNT), 32'd0);
    checkOutput("mrst_m_tvalid", 32'(M_AXIS_TVALID), 32'd0);
    checkOutput("mrst_s_tready", 32'(S_AXIS_TREADY), 32'd0);
    applyStimulus(0, 2, 32'h4000_0000, -1, 0);
    applyStimulus(1, 2, 32'h4000_0110, -1, 0);
    stepCycles(2);
    checkOutput("mrst_next_grant_idx", 32'(GRANT_IDX), 32'd0);
    checkOutput("mrst_next_grant_vld", 32'(GRANT_VLD), 32'd1);
    waitDrain(30);
    stepCycles(1);
    checkOutput("mrst_final_pkt_cnt", PKT_CNT, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
